// File: rtl/pulse_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pulse_pkg
// Purpose : Shared types, default widths and configuration validity check
//           for the pulse_train_ctrl block.
// Contents:
//   DEF_CNT_W / DEF_NUM_W  default widths of timing fields and pulse count
//   state_t                controller state encoding (IDLE, HIGH, LOW, DONE)
//   cfg_valid()            accept/reject decision for a start request
// Options : PULSE_TRAIN_CONTINUOUS_EN - when defined, num_pulses == 0 is a
//           valid request meaning "run until stop".
// Revision: 1.0 - initial release
// ============================================================================
package pulse_pkg;

  localparam int DEF_CNT_W = 16;
  localparam int DEF_NUM_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Arguments are zero-extended to 32 bits by the caller so the check is
  // independent of the instance widths.
  function automatic logic cfg_valid(input logic [31:0] period,
                                     input logic [31:0] high_len,
                                     input logic [31:0] num_pulses);
    logic timing_ok;
    timing_ok = (high_len != 32'd0) && (high_len < period);
`ifdef PULSE_TRAIN_CONTINUOUS_EN
    // Zero pulses selects continuous mode, so any count is acceptable.
    cfg_valid = timing_ok;
`else
    cfg_valid = timing_ok && (num_pulses != 32'd0);
`endif
  endfunction

endpackage
`default_nettype wire

// File: rtl/phase_timer.sv
`default_nettype none
// ============================================================================
// Module  : phase_timer
// Purpose : Loadable/clearable binary phase counter with a terminal flag.
// Ports   :
//   clk    in   clock, rising edge
//   reset  in   synchronous active-high reset (count -> 0)
//   clr    in   synchronous clear, has priority over en
//   en     in   count enable
//   len    in   phase length in cycles (must be >= 1 while in use)
//   term   out  high when the count equals len-1 (last cycle of the phase)
// Revision: 1.0 - initial release
// ============================================================================
module phase_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] len,
  output logic             term
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  // The owner clears on every terminal, so count never passes len-1 and the
  // increment cannot wrap even for len = 2^CNT_W-1.
  assign term = (count == (len - 1'b1));

endmodule
`default_nettype wire

// File: rtl/pulse_train_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pulse_train_ctrl
// Purpose : Generates a bounded train of num_pulses pulses, each high for
//           high_len cycles and repeating every period cycles.
// Ports   :
//   clk         in   clock, rising edge
//   reset       in   synchronous active-high reset
//   start       in   request a train (sampled only in IDLE)
//   stop        in   abort a running train
//   period      in   cycles per pulse (latched on accepted start)
//   high_len    in   high cycles per pulse (latched on accepted start)
//   num_pulses  in   pulses per train (latched on accepted start)
//   pulse_out   out  registered pulse output
//   busy        out  state != IDLE
//   done        out  one-cycle strobe after the last pulse
//   aborted     out  one-cycle strobe when stop ends a train
//   cfg_err     out  one-cycle strobe when start is rejected
//   pulse_cnt   out  pulses started in the current/last train
// Options : PULSE_TRAIN_CONTINUOUS_EN - num_pulses == 0 runs until stop,
//           pulse_cnt wraps and DONE is never entered.
// Revision: 1.0 - initial release
// ============================================================================
module pulse_train_ctrl
  import pulse_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int NUM_W = DEF_NUM_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] high_len,
  input  logic [NUM_W-1:0] num_pulses,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             cfg_err,
  output logic [NUM_W-1:0] pulse_cnt
);

  state_t           state;
  state_t           state_next;

  logic [CNT_W-1:0] period_lat;
  logic [CNT_W-1:0] high_lat;
  logic [NUM_W-1:0] num_lat;
  logic [CNT_W-1:0] low_len;
  logic [CNT_W-1:0] phase_len;

  logic             cfg_ok;
  logic             start_ok;
  logic             last_pulse;
  logic             timer_term;
  logic             timer_clr;
  logic             timer_en;

  logic             pulse_next;
  logic             done_next;
  logic             aborted_next;
  logic             cfg_err_next;

  assign cfg_ok   = cfg_valid(32'(period), 32'(high_len), 32'(num_pulses));
  assign start_ok = (state == ST_IDLE) && start && !stop && cfg_ok;

  // Cannot underflow: high_lat < period_lat is guaranteed by cfg_valid.
  assign low_len   = period_lat - high_lat;
  assign phase_len = (state == ST_LOW) ? low_len : high_lat;

`ifdef PULSE_TRAIN_CONTINUOUS_EN
  // A zero count means continuous; pulse_cnt may wrap to 0, so it must not
  // be mistaken for the end of the train.
  assign last_pulse = (num_lat != '0) && (pulse_cnt == num_lat);
`else
  assign last_pulse = (pulse_cnt == num_lat);
`endif

  // Every state change starts a fresh phase, so one clear covers start
  // acceptance, HIGH->LOW, LOW->HIGH and aborts.
  assign timer_clr = (state_next != state);
  assign timer_en  = (state == ST_HIGH) || (state == ST_LOW);

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_phase_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (timer_clr),
    .en    (timer_en),
    .len   (phase_len),
    .term  (timer_term)
  );

  // --------------------------------------------------------------------------
  // State register (outputs registered alongside so they follow state exactly)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      pulse_out <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      state     <= state_next;
      pulse_out <= pulse_next;
      done      <= done_next;
      aborted   <= aborted_next;
      cfg_err   <= cfg_err_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic; stop has priority over phase terminals
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start_ok) state_next = ST_HIGH;
      end
      ST_HIGH: begin
        if (stop)            state_next = ST_IDLE;
        else if (timer_term) state_next = ST_LOW;
      end
      ST_LOW: begin
        if (stop)            state_next = ST_IDLE;
        else if (timer_term) state_next = last_pulse ? ST_DONE : ST_HIGH;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic: values the output registers take at the next edge
  // --------------------------------------------------------------------------
  always_comb begin
    pulse_next   = (state_next == ST_HIGH);
    done_next    = (state_next == ST_DONE);
    aborted_next = stop && ((state == ST_HIGH) || (state == ST_LOW));
    cfg_err_next = (state == ST_IDLE) && start && !stop && !cfg_ok;
  end

  assign busy = (state != ST_IDLE);

  // --------------------------------------------------------------------------
  // Latched configuration and pulse counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      period_lat <= '0;
      high_lat   <= '0;
      num_lat    <= '0;
      pulse_cnt  <= '0;
    end else if (start_ok) begin
      period_lat <= period;
      high_lat   <= high_len;
      num_lat    <= num_pulses;
      pulse_cnt  <= NUM_W'(1);
    end else if ((state == ST_LOW) && !stop && timer_term && !last_pulse) begin
      // Wraps naturally in continuous mode; bounded by num_lat otherwise.
      pulse_cnt  <= pulse_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire
